clock_set_controller: RTL and testbench

- Front-panel controller that drives the time counter's UI interface.
- Synchronises and debounces two raw push-buttons (MODE, INC) and runs a set-mode FSM.
- Emits single-cycle inc_hours_ui / inc_minutes_ui / inc_seconds_ui pulses, with auto-repeat while INC is held.
- Gates the 1 Hz enable forwarded to the time counter, and provides field-select and blink outputs for the display.

---
 rtl/clock_ui_pkg.sv | 19 +
 rtl/button_debouncer.sv | 61 ++++++
 rtl/clock_set_controller.sv | 163 ++++++++++++++++
 tb/tb_clock_set_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/clock_ui_pkg.sv
// Shared types and width helpers for the front-panel clock-setting logic.
package clock_ui_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        SET_SEC = 2'b11
    } set_mode_t;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stability-count debouncer for one raw push-button;
// emits the accepted level and a one-cycle pulse on its rising edge.
module button_debouncer
    import clock_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        cnt_d   = {CW{1'b0}};
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            // Terminal count: accept the new level; only a rise yields a pulse.
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/clock_set_controller.sv
// Front-panel set-mode controller: debounced MODE/INC buttons, field-select FSM,
// increment pulses with auto-repeat, inactivity timeout and field blink.
module clock_set_controller
    import clock_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int HOLD_DELAY_CYCLES = 25000000,
    parameter int REPEAT_CYCLES     = 5000000,
    parameter int TIMEOUT_TICKS     = 10
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       btn_mode_raw,
    input  logic       btn_inc_raw,
    input  logic       clk_1hz_en,
    output logic       clk_1hz_en_out,
    output logic       inc_hours_ui,
    output logic       inc_minutes_ui,
    output logic       inc_seconds_ui,
    output logic [1:0] set_mode,
    output logic       blink
);

    localparam int HW = cnt_width(max_int(HOLD_DELAY_CYCLES, REPEAT_CYCLES));
    localparam int TW = cnt_width(TIMEOUT_TICKS);

    logic mode_level_s, mode_pulse_s, inc_level_s, inc_pulse_s;
    logic mode_press_s, inc_press_s, in_set_s, state_change_s;
    logic inc_accept_s, repeat_s, timeout_s, fire_s;
    logic [HW-1:0] hold_term_s;

    set_mode_t     state_q, state_d;
    logic          inc_hours_q, inc_hours_d;
    logic          inc_minutes_q, inc_minutes_d;
    logic          inc_seconds_q, inc_seconds_d;
    logic          blink_q, blink_d;
    logic          hold_active_q, hold_active_d;
    logic          rep_phase_q, rep_phase_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk(sys_clk), .rst(rst), .btn_raw(btn_mode_raw),
        .level(mode_level_s), .press(mode_pulse_s)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .clk(sys_clk), .rst(rst), .btn_raw(btn_inc_raw),
        .level(inc_level_s), .press(inc_pulse_s)
    );

    // Press qualification: MODE beats INC; a timeout is averted by any INC activity.
    always_comb begin
        mode_press_s = mode_pulse_s & mode_level_s;
        inc_press_s  = inc_pulse_s & inc_level_s;
        in_set_s     = (state_q != RUN);
        hold_term_s  = rep_phase_q ? HW'(REPEAT_CYCLES) : HW'(HOLD_DELAY_CYCLES);
        inc_accept_s = inc_press_s & in_set_s & ~mode_press_s;
        repeat_s     = hold_active_q & inc_level_s & (hold_cnt_q == hold_term_s) & ~mode_press_s;
        fire_s       = inc_accept_s | repeat_s;
        timeout_s    = in_set_s & clk_1hz_en & (to_cnt_q == TW'(TIMEOUT_TICKS - 1)) & ~fire_s;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout_s) begin
            state_d = RUN;
        end else if (mode_press_s) begin
            case (state_q)
                RUN:     state_d = SET_HR;
                SET_HR:  state_d = SET_MIN;
                SET_MIN: state_d = SET_SEC;
                SET_SEC: state_d = RUN;
                default: state_d = RUN;
            endcase
        end else begin
            state_d = state_q;
        end
        state_change_s = (state_d != state_q);
    end

    always_comb begin
        inc_hours_d   = 1'b0;
        inc_minutes_d = 1'b0;
        inc_seconds_d = 1'b0;
        case (state_q)
            SET_HR:  inc_hours_d   = fire_s;
            SET_MIN: inc_minutes_d = fire_s;
            SET_SEC: inc_seconds_d = fire_s;
            default: inc_hours_d   = 1'b0;
        endcase
    end

    // Hold/repeat tracking and inactivity timeout; both restart on any state change.
    always_comb begin
        hold_active_d = 1'b0;
        hold_cnt_d    = {HW{1'b0}};
        rep_phase_d   = 1'b0;
        to_cnt_d      = to_cnt_q;
        blink_d       = 1'b0;
        if (inc_accept_s) begin
            hold_active_d = 1'b1;
            hold_cnt_d    = HW'(1);
        end else if (hold_active_q && inc_level_s && !state_change_s) begin
            hold_active_d = 1'b1;
            rep_phase_d   = rep_phase_q | repeat_s;
            hold_cnt_d    = repeat_s ? HW'(1) : hold_cnt_q + HW'(1);
        end else begin
            hold_active_d = 1'b0;
        end
        if (state_change_s || !in_set_s) begin
            to_cnt_d = {TW{1'b0}};
            blink_d  = 1'b0;
        end else begin
            blink_d = blink_q ^ clk_1hz_en;
            if (fire_s) begin
                to_cnt_d = {TW{1'b0}};
            end else if (clk_1hz_en) begin
                to_cnt_d = to_cnt_q + TW'(1);
            end else begin
                to_cnt_d = to_cnt_q;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            inc_hours_q   <= 1'b0;
            inc_minutes_q <= 1'b0;
            inc_seconds_q <= 1'b0;
            blink_q       <= 1'b0;
            hold_active_q <= 1'b0;
            rep_phase_q   <= 1'b0;
            hold_cnt_q    <= {HW{1'b0}};
            to_cnt_q      <= {TW{1'b0}};
        end else begin
            inc_hours_q   <= inc_hours_d;
            inc_minutes_q <= inc_minutes_d;
            inc_seconds_q <= inc_seconds_d;
            blink_q       <= blink_d;
            hold_active_q <= hold_active_d;
            rep_phase_q   <= rep_phase_d;
            hold_cnt_q    <= hold_cnt_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign clk_1hz_en_out = clk_1hz_en & (state_q == RUN);
    assign inc_hours_ui   = inc_hours_q;
    assign inc_minutes_ui = inc_minutes_q;
    assign inc_seconds_ui = inc_seconds_q;
    assign set_mode       = state_q;
    assign blink          = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with small timing parameters.
module tb_clock_set_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode_raw = 1'b0;
    logic       btn_inc_raw = 1'b0;
    logic       clk_1hz_en = 1'b0;
    logic       clk_1hz_en_out;
    logic       inc_hours_ui, inc_minutes_ui, inc_seconds_ui;
    logic [1:0] set_mode;
    logic       blink;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int multi = 0;
    int hr_q[$];
    int min_q[$];
    int sec_q[$];
    int e0;
    int p;

    clock_set_controller #(
        .DEBOUNCE_CYCLES(4), .HOLD_DELAY_CYCLES(20), .REPEAT_CYCLES(5), .TIMEOUT_TICKS(3)
    ) dut (
        .sys_clk(clk), .rst(rst), .btn_mode_raw(btn_mode_raw), .btn_inc_raw(btn_inc_raw),
        .clk_1hz_en(clk_1hz_en), .clk_1hz_en_out(clk_1hz_en_out),
        .inc_hours_ui(inc_hours_ui), .inc_minutes_ui(inc_minutes_ui),
        .inc_seconds_ui(inc_seconds_ui), .set_mode(set_mode), .blink(blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Log the edge index preceding every increment pulse.
    always @(negedge clk) begin
        if (inc_hours_ui)   hr_q.push_back(cyc);
        if (inc_minutes_ui) min_q.push_back(cyc);
        if (inc_seconds_ui) sec_q.push_back(cyc);
        if (int'(inc_hours_ui) + int'(inc_minutes_ui) + int'(inc_seconds_ui) > 1) multi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_mode();
        btn_mode_raw = 1'b1;
        step(10);
        btn_mode_raw = 1'b0;
        step(10);
    endtask

    task automatic check_gate(input string tag, input logic exp);
        clk_1hz_en = 1'b1;
        #1;
        chk(tag, clk_1hz_en_out, exp);
        clk_1hz_en = 1'b0;
        #1;
    endtask

    task automatic tick_and_check(input string tag, input logic [1:0] exp_mode, input logic exp_blink);
        clk_1hz_en = 1'b1;
        step(1);
        clk_1hz_en = 1'b0;
        chk({tag, "_mode"}, set_mode, exp_mode);
        chk({tag, "_blink"}, blink, exp_blink);
        step(3);
    endtask

    initial begin
        // Reset state
        step(3);
        chk("rst_mode", set_mode, 2'b00);
        chk("rst_incs", {inc_hours_ui, inc_minutes_ui, inc_seconds_ui}, 3'b000);
        chk("rst_blink", blink, 1'b0);
        rst = 1'b0;
        step(2);

        // 1: MODE cycling and tick gating
        check_gate("gate_run0", 1'b1);
        press_mode();
        chk("mode_hr", set_mode, 2'b01);
        check_gate("gate_hr", 1'b0);
        press_mode();
        chk("mode_min", set_mode, 2'b10);
        check_gate("gate_min", 1'b0);
        press_mode();
        chk("mode_sec", set_mode, 2'b11);
        check_gate("gate_sec", 1'b0);
        press_mode();
        chk("mode_run", set_mode, 2'b00);
        check_gate("gate_run1", 1'b1);

        // 2: single INC press in SET_MIN, pulse exactly 7 edges after raw is driven
        press_mode();
        press_mode();
        chk("t2_mode", set_mode, 2'b10);
        hr_q.delete(); min_q.delete(); sec_q.delete();
        e0 = cyc;
        btn_inc_raw = 1'b1;
        step(10);
        btn_inc_raw = 1'b0;
        step(15);
        chk("t2_min_count", min_q.size(), 1);
        if (min_q.size() > 0) chk("t2_min_time", min_q[0], e0 + 7);
        chk("t2_other", hr_q.size() + sec_q.size(), 0);

        // 3: bouncing INC never accepted
        hr_q.delete(); min_q.delete(); sec_q.delete();
        btn_inc_raw = 1'b1; step(3);
        btn_inc_raw = 1'b0; step(1);
        btn_inc_raw = 1'b1; step(3);
        btn_inc_raw = 1'b0; step(20);
        chk("t3_pulses", hr_q.size() + min_q.size() + sec_q.size(), 0);
        chk("t3_mode", set_mode, 2'b10);

        // 4: auto-repeat in SET_HR
        press_mode();
        press_mode();
        press_mode();
        chk("t4_mode", set_mode, 2'b01);
        hr_q.delete(); min_q.delete(); sec_q.delete();
        e0 = cyc;
        p = e0 + 7;
        btn_inc_raw = 1'b1;
        step(40);
        btn_inc_raw = 1'b0;
        step(30);
        chk("t4_count", hr_q.size(), 5);
        if (hr_q.size() == 5) begin
            chk("t4_p0", hr_q[0], p);
            chk("t4_p1", hr_q[1], p + 20);
            chk("t4_p2", hr_q[2], p + 25);
            chk("t4_p3", hr_q[3], p + 30);
            chk("t4_p4", hr_q[4], p + 35);
        end
        chk("t4_other", min_q.size() + sec_q.size(), 0);

        // 5: timeout from SET_SEC after three ticks
        press_mode();
        press_mode();
        chk("t5_mode", set_mode, 2'b11);
        tick_and_check("t5_tick1", 2'b11, 1'b1);
        tick_and_check("t5_tick2", 2'b11, 1'b0);
        tick_and_check("t5_tick3", 2'b00, 1'b0);
        check_gate("t5_tick4_out", 1'b1);

        // 6: reset during auto-repeat hold in SET_MIN
        press_mode();
        press_mode();
        chk("t6_mode", set_mode, 2'b10);
        hr_q.delete(); min_q.delete(); sec_q.delete();
        e0 = cyc;
        p = e0 + 7;
        btn_inc_raw = 1'b1;
        step(29);
        chk("t6_pre_count", min_q.size(), 2);
        if (min_q.size() == 2) chk("t6_pre_rep", min_q[1], p + 20);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6_mode_rst", set_mode, 2'b00);
        chk("t6_incs_rst", {inc_hours_ui, inc_minutes_ui, inc_seconds_ui}, 3'b000);
        chk("t6_blink_rst", blink, 1'b0);
        hr_q.delete(); min_q.delete(); sec_q.delete();
        step(40);
        btn_inc_raw = 1'b0;
        step(10);
        chk("t6_post_pulses", hr_q.size() + min_q.size() + sec_q.size(), 0);
        chk("t6_post_mode", set_mode, 2'b00);

        chk("onehot", multi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
